// File: rtl/cmp_swap.sv
// ============================================================================
// Module   : cmp_swap
// Brief    : Combinational compare-exchange; smaller value on lo, larger on hi.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_swap #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] hi
);

    logic w_a_lt_b;

    assign w_a_lt_b = (a < b);
    assign lo       = w_a_lt_b ? a : b;
    assign hi       = w_a_lt_b ? b : a;

endmodule

`default_nettype wire

// File: rtl/sb.sv
// ============================================================================
// Module   : sb
// Brief    : Registered three-input unsigned sorter built from a three-step
//            compare-exchange network; one cycle latency, full throughput.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb #(
    parameter int DATA_WIDTH = 8
) (
    output logic [DATA_WIDTH-1:0] min,
    output logic [DATA_WIDTH-1:0] med,
    output logic [DATA_WIDTH-1:0] max,
    input  logic [DATA_WIDTH-1:0] _1,
    input  logic [DATA_WIDTH-1:0] _2,
    input  logic [DATA_WIDTH-1:0] _3,
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  out_valid
);

    logic [DATA_WIDTH-1:0] w_lo1, w_hi1;
    logic [DATA_WIDTH-1:0] w_lo2, w_hi2;
    logic [DATA_WIDTH-1:0] w_lo3, w_hi3;

    logic [DATA_WIDTH-1:0] r_min, r_med, r_max;
    logic                  r_valid;

    // Step 2 pushes the overall maximum into w_hi2; step 3 orders the rest.
    cmp_swap #(.DATA_WIDTH(DATA_WIDTH)) u_cs1 (.a(_1),    .b(_2),    .lo(w_lo1), .hi(w_hi1));
    cmp_swap #(.DATA_WIDTH(DATA_WIDTH)) u_cs2 (.a(w_hi1), .b(_3),    .lo(w_lo2), .hi(w_hi2));
    cmp_swap #(.DATA_WIDTH(DATA_WIDTH)) u_cs3 (.a(w_lo1), .b(w_lo2), .lo(w_lo3), .hi(w_hi3));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_min   <= '0;
            r_med   <= '0;
            r_max   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_min <= w_lo3;
                r_med <= w_hi3;
                r_max <= w_hi2;
            end
        end
    end

    assign min       = r_min;
    assign med       = r_med;
    assign max       = r_max;
    assign out_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_sb.sv
// ============================================================================
// Module   : tb_sb
// Brief    : Self-checking bench for sb: per-cycle reference model plus
//            directed vectors with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sb;

    localparam int DATA_WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic [DATA_WIDTH-1:0] _1 = '0, _2 = '0, _3 = '0;
    logic [DATA_WIDTH-1:0] min, med, max;
    logic                  out_valid;

    int passed = 0;
    int total  = 0;

    // Reference state, updated at each rising edge from the spec rules.
    int m_min = 0, m_med = 0, m_max = 0;
    bit m_valid = 1'b0;

    sb #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .min(min), .med(med), .max(max),
        ._1(_1), ._2(_2), ._3(_3),
        .clk(clk), .rst(rst), .in_valid(in_valid), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(posedge clk) begin
        int a, b, c, lo, hi;
        if (rst) begin
            m_min = 0; m_med = 0; m_max = 0; m_valid = 1'b0;
        end else begin
            m_valid = in_valid;
            if (in_valid) begin
                a = int'(_1); b = int'(_2); c = int'(_3);
                lo = a; if (b < lo) lo = b; if (c < lo) lo = c;
                hi = a; if (b > hi) hi = b; if (c > hi) hi = c;
                m_min = lo; m_max = hi; m_med = a + b + c - lo - hi;
            end
        end
    end

    always @(negedge clk) begin
        check("model_min", int'(min), m_min);
        check("model_med", int'(med), m_med);
        check("model_max", int'(max), m_max);
        check("model_valid", int'(out_valid), int'(m_valid));
    end

    task automatic apply(input int a, input int b, input int c,
                         input int emin, input int emed, input int emax,
                         input string name);
        _1 = DATA_WIDTH'(a); _2 = DATA_WIDTH'(b); _3 = DATA_WIDTH'(c);
        in_valid = 1'b1;
        @(posedge clk); #1;
        check({name, "_min"}, int'(min), emin);
        check({name, "_med"}, int'(med), emed);
        check({name, "_max"}, int'(max), emax);
        check({name, "_vld"}, int'(out_valid), 1);
    endtask

    initial begin
        // Reset with garbage and in_valid asserted.
        rst = 1'b1; in_valid = 1'b1; _1 = 8'd77; _2 = 8'd3; _3 = 8'd200;
        repeat (2) @(posedge clk);
        #1;
        check("rst_min", int'(min), 0);
        check("rst_med", int'(med), 0);
        check("rst_max", int'(max), 0);
        check("rst_vld", int'(out_valid), 0);
        rst = 1'b0;

        apply(200,   0,   0,   0,   0, 200, "s1a");
        apply(200, 255,   0,   0, 200, 255, "s1b");
        apply(200, 255, 220, 200, 220, 255, "s1c");
        apply(200, 100, 220, 100, 200, 220, "s2a");
        apply(200, 100,  10,  10, 100, 200, "s2b");
        apply(  1, 100,  10,   1,  10, 100, "s2c");
        apply(145, 145, 145, 145, 145, 145, "tie3");
        apply(  7,   7,   3,   3,   7,   7, "tie2");
        apply(255,   0, 255,   0, 255, 255, "bound");

        // Hold: drop in_valid and disturb the inputs.
        apply(5, 9, 1, 1, 5, 9, "hold_load");
        in_valid = 1'b0; _1 = 8'd100; _2 = 8'd200; _3 = 8'd50;
        @(posedge clk); #1;
        check("hold_min", int'(min), 1);
        check("hold_med", int'(med), 5);
        check("hold_max", int'(max), 9);
        check("hold_vld", int'(out_valid), 0);
        @(posedge clk); #1;
        check("hold2_med", int'(med), 5);

        // Reset mid-stream has priority over a valid triple.
        rst = 1'b1; in_valid = 1'b1; _1 = 8'd30; _2 = 8'd20; _3 = 8'd10;
        @(posedge clk); #1;
        check("mrst_min", int'(min), 0);
        check("mrst_med", int'(med), 0);
        check("mrst_max", int'(max), 0);
        check("mrst_vld", int'(out_valid), 0);
        rst = 1'b0;
        apply(4, 250, 0, 0, 4, 250, "post_rst");

        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
